// File: rtl/seq_divider.sv
// Iterative restoring divider: N_W-bit dividend by D_W-bit divisor, one quotient bit per clock.
// Define SIGNED_DIV_EN to add the signed_op port for two's-complement truncating division.
module seq_divider #(
    parameter int N_W = 32,
    parameter int D_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
`ifdef SIGNED_DIV_EN
    input  logic           signed_op,
`endif
    output logic           busy,
    output logic           done,
    output logic [N_W-1:0] quotient,
    output logic [D_W-1:0] remainder,
    output logic           div_by_zero
);

    localparam int CNT_W = $clog2(N_W) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [D_W:0]   prem_q, prem_d;
    logic [N_W-1:0] shreg_q, shreg_d;
    logic [D_W-1:0] dvsr_q, dvsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_W-1:0] quot_q, quot_d;
    logic [D_W-1:0] rem_q, rem_d;
    logic           dbz_q, dbz_d;
    logic           zero_q, zero_d;
`ifdef SIGNED_DIV_EN
    logic           qneg_q, qneg_d;
    logic           rneg_q, rneg_d;
`endif

    logic [D_W+1:0] shifted;
    logic [D_W+1:0] trial;
    logic           qbit;
    logic [D_W:0]   prem_nxt;
    logic [N_W-1:0] shreg_nxt;
    logic [N_W-1:0] quot_fin;
    logic [D_W-1:0] rem_fin;
    logic [N_W-1:0] a_mag;
    logic [D_W-1:0] b_mag;
    logic           last_iter;

    // One restoring step; the extra top bit of trial is the borrow.
    always_comb begin
        shifted   = {prem_q, shreg_q[N_W-1]};
        trial     = shifted - {2'b00, dvsr_q};
        qbit      = ~trial[D_W+1];
        prem_nxt  = qbit ? trial[D_W:0] : shifted[D_W:0];
        shreg_nxt = {shreg_q[N_W-2:0], qbit};
        last_iter = (cnt_q == CNT_W'(N_W - 1));
    end

    always_comb begin
        a_mag    = dividend;
        b_mag    = divisor;
        quot_fin = shreg_nxt;
        rem_fin  = prem_nxt[D_W-1:0];
`ifdef SIGNED_DIV_EN
        if (signed_op && dividend[N_W-1]) a_mag = -dividend;
        if (signed_op && divisor[D_W-1])  b_mag = -divisor;
        if (qneg_q) quot_fin = -shreg_nxt;
        if (rneg_q) rem_fin  = -prem_nxt[D_W-1:0];
`endif
    end

    always_comb begin
        state_d = state_q;
        prem_d  = prem_q;
        shreg_d = shreg_q;
        dvsr_d  = dvsr_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        zero_d  = zero_q;
`ifdef SIGNED_DIV_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) state_d = IDLE;
                if (start) begin
                    // A zero divisor also spends one RUN cycle so its done lands on edge k+1.
                    state_d = RUN;
                    prem_d  = '0;
                    cnt_d   = '0;
                    dbz_d   = 1'b0;
                    zero_d  = (divisor == '0);
                    dvsr_d  = b_mag;
                    shreg_d = (divisor == '0) ? dividend : a_mag;
`ifdef SIGNED_DIV_EN
                    qneg_d  = signed_op & (dividend[N_W-1] ^ divisor[D_W-1]);
                    rneg_d  = signed_op & dividend[N_W-1];
`endif
                end
            end
            RUN: begin
                if (zero_q) begin
                    state_d = DONE;
                    quot_d  = '1;
                    rem_d   = shreg_q[D_W-1:0];
                    dbz_d   = 1'b1;
                    zero_d  = 1'b0;
                end else begin
                    prem_d  = prem_nxt;
                    shreg_d = shreg_nxt;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        state_d = DONE;
                        quot_d  = quot_fin;
                        rem_d   = rem_fin;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prem_q  <= '0;
            shreg_q <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            zero_q  <= 1'b0;
`ifdef SIGNED_DIV_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            prem_q  <= prem_d;
            shreg_q <= shreg_d;
            dvsr_q  <= dvsr_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            zero_q  <= zero_d;
`ifdef SIGNED_DIV_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider; expected results queued at start, checked at done.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        signed_op;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    always #5 clk = ~clk;

    seq_divider #(.N_W(32), .D_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
`ifdef SIGNED_DIV_EN
        .signed_op  (signed_op),
`endif
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    typedef struct {
        logic [31:0] q;
        logic [15:0] r;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] mq(input logic [31:0] a, input logic [15:0] b);
        return (b == 16'd0) ? 32'hFFFFFFFF : a / {16'd0, b};
    endfunction

    function automatic logic [15:0] mr(input logic [31:0] a, input logic [15:0] b);
        logic [31:0] t;
        t = (b == 16'd0) ? a : a % {16'd0, b};
        return t[15:0];
    endfunction

    // Drive a start for one edge and queue the expected result; returns #1 after that edge.
    task automatic launch(input logic [31:0] a, input logic [15:0] b, input logic s,
                          input logic [31:0] eq, input logic [15:0] er, input logic edbz);
        exp_t e;
        e.q = eq; e.r = er; e.dbz = edbz; e.lat = (b == 16'd0) ? 1 : 32;
        sb.push_back(e);
        dividend  = a;
        divisor   = b;
        signed_op = s;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        $display("start  a=%h b=%h signed=%0d", a, b, s);
    endtask

    task automatic launch_u(input logic [31:0] a, input logic [15:0] b);
        launch(a, b, 1'b0, mq(a, b), mr(a, b), b == 16'd0);
    endtask

    // Waits for done; skip = edges already elapsed since the start edge.
    task automatic wait_done(input string tag, input int skip, input bit chk_drop);
        exp_t e;
        int   n;
        int   bcnt;
        bit   seen;
        seen = 1'b0;
        n    = skip;
        bcnt = busy ? 1 : 0;
        while (!seen && n < skip + 40) begin
            @(posedge clk); #1;
            n++;
            if (done) seen = 1'b1;
            else if (busy) bcnt++;
        end
        chk({tag, " sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk({tag, " latency"}, seen ? 32'(n) : 32'd0, 32'(e.lat));
        if (skip == 0 && e.lat == 32) chk({tag, " busy_cycles"}, 32'(bcnt), 32'd32);
        if (seen) begin
            chk({tag, " quotient"}, quotient, e.q);
            chk({tag, " remainder"}, {16'd0, remainder}, {16'd0, e.r});
            chk({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
            $display("done   %s q=%h r=%h dbz=%0d lat=%0d", tag, quotient, remainder, div_by_zero, n);
        end
        if (chk_drop) begin
            @(posedge clk); #1;
            chk({tag, " done_drop"}, {31'd0, done}, 32'd0);
            chk({tag, " dbz_held"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
        end
    endtask

    initial begin
        int   dcnt;
        logic [31:0] ra;
        logic [15:0] rb;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0; signed_op = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", {16'd0, remainder}, 32'd0);
        chk("reset dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        launch_u(32'd100, 16'd7);             wait_done("100/7", 0, 1'b1);
        launch_u(32'hFFFFFFFF, 16'hFFFF);     wait_done("max/max", 0, 1'b1);
        launch_u(32'hFFFE0001, 16'hFFFF);     wait_done("prod/max", 0, 1'b1);
        launch_u(32'h00012345, 16'd0);       wait_done("div0", 0, 1'b1);
        launch_u(32'd100, 16'd7);             wait_done("dbz_clear", 0, 1'b1);

        // Second start during RUN must be ignored.
        launch_u(32'd1000, 16'd3);
        repeat (9) begin @(posedge clk); #1; end
        dividend = 32'd50; divisor = 16'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ignored_start busy", {31'd0, busy}, 32'd1);
        wait_done("1000/3", 10, 1'b0);

        // Start accepted in the DONE cycle.
        launch_u(32'd100, 16'd7);
        chk("done_start done_low", {31'd0, done}, 32'd0);
        chk("done_start busy", {31'd0, busy}, 32'd1);
        wait_done("done_start", 0, 1'b1);

        // Asynchronous reset in the middle of an operation.
        launch_u(32'h12345678, 16'h1234);
        repeat (14) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst done", {31'd0, done}, 32'd0);
        chk("midrst quotient", quotient, 32'd0);
        chk("midrst remainder", {16'd0, remainder}, 32'd0);
        void'(sb.pop_front());
        @(negedge clk); rst = 1'b0;
        dcnt = 0;
        repeat (40) begin @(posedge clk); #1; if (done) dcnt++; end
        chk("midrst no_done", 32'(dcnt), 32'd0);
        $display("reset  mid-operation, done pulses seen=%0d", dcnt);
        launch_u(32'd12345, 16'd17);          wait_done("after_rst", 0, 1'b1);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = 16'($urandom_range(1, 65535));
            launch_u(ra, rb);
            wait_done("random", 0, 1'b1);
        end

`ifdef SIGNED_DIV_EN
        launch(32'hFFFFFFF9, 16'd2, 1'b1, 32'hFFFFFFFD, 16'hFFFF, 1'b0);    wait_done("s -7/2", 0, 1'b1);
        launch(32'd7, 16'hFFFE, 1'b1, 32'hFFFFFFFD, 16'd1, 1'b0);           wait_done("s 7/-2", 0, 1'b1);
        launch(32'h80000000, 16'hFFFF, 1'b1, 32'h80000000, 16'd0, 1'b0);   wait_done("s min/-1", 0, 1'b1);
        launch(32'hFFFFFFF9, 16'd0, 1'b1, 32'hFFFFFFFF, 16'hFFF9, 1'b1);    wait_done("s div0", 0, 1'b1);
        launch(32'hFFFFFFF9, 16'd2, 1'b0, 32'h7FFFFFFC, 16'd1, 1'b0);       wait_done("u big/2", 0, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
